spi_counter_master: RTL and testbench



---
 rtl/spi_counter_master.sv | 166 ++++++++++++++++
 tb/tb_spi_counter_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_counter_master.sv
// rtl/spi_counter_master.sv - SPI mode-0 master sending a 14-bit counter as one 16-bit frame
//
// Purpose:
//   Sends {2'b00, count_data} MSB first as two back-to-back bytes (upper
//   byte first) with ss held low for the whole frame. All outputs are
//   registered.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       request to send; only sampled while idle
//   count_data  14-bit value captured on the cycle start is accepted
//   sclk        SPI clock, idles low
//   mosi        SPI data out, MSB first
//   ss          slave select, active low
//   busy        high while a frame is in progress
//   done        one-cycle pulse on the last busy cycle of a frame
//
// Parameters:
//   CLK_DIV     clk cycles per sclk half-period (must be >= 1)

module spi_counter_master #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] count_data,
    output logic        sclk,
    output logic        mosi,
    output logic        ss,
    output logic        busy,
    output logic        done
);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_counter_master: CLK_DIV must be at least 1");
    end

    // At least one bit wide so CLK_DIV=1 still has a legal counter.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_H,
        ST_SCLK_L,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      frame_reg;
    logic [15:0]      frame_next;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_next;
    logic             half_end;

    logic             sclk_next;
    logic             mosi_next;
    logic             ss_next;
    logic             busy_next;
    logic             done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame_reg <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            frame_reg <= frame_next;
            div_cnt   <= div_next;
            bit_cnt   <= bit_next;
            sclk      <= sclk_next;
            mosi      <= mosi_next;
            ss        <= ss_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_next = frame_reg;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        half_end   = (div_cnt == DIV_LAST);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    frame_next = {2'b00, count_data};
                    div_next   = '0;
                    bit_next   = '0;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (half_end) begin
                    div_next   = '0;
                    state_next = ST_SCLK_H;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            ST_SCLK_H: begin
                if (half_end) begin
                    div_next = '0;
                    if (bit_cnt == 4'd15) begin
                        // Last bit stays in frame_reg[15] so mosi holds it through HOLD.
                        state_next = ST_HOLD;
                    end else begin
                        frame_next = {frame_reg[14:0], 1'b0};
                        bit_next   = bit_cnt + 4'd1;
                        state_next = ST_SCLK_L;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            ST_SCLK_L: begin
                if (half_end) begin
                    div_next   = '0;
                    state_next = ST_SCLK_H;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (half_end) begin
                    div_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up cycle-for-cycle with the state they describe.
        sclk_next = (state_next == ST_SCLK_H);
        ss_next   = !((state_next == ST_SETUP)  || (state_next == ST_SCLK_H) ||
                      (state_next == ST_SCLK_L) || (state_next == ST_HOLD));
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
        mosi_next = ss_next ? 1'b0 : frame_next[15];
    end

endmodule

// File: tb/tb_spi_counter_master.sv
// tb/tb_spi_counter_master.sv - directed self-checking bench for spi_counter_master
module tb_spi_counter_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start2, start1;
    logic [13:0] cd2, cd1;
    logic        sclk2, mosi2, ss2, busy2, done2;
    logic        sclk1, mosi1, ss1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_counter_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .count_data(cd2),
        .sclk(sclk2), .mosi(mosi2), .ss(ss2), .busy(busy2), .done(done2)
    );

    spi_counter_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .count_data(cd1),
        .sclk(sclk1), .mosi(mosi1), .ss(ss1), .busy(busy1), .done(done1)
    );

    // Slave-side monitors, sampled on the falling clk edge.
    logic [15:0] cap2, cap1;
    logic [15:0] flog2 [0:7];
    int rise2, busy_cnt2, ss_low2, done_cnt2, done_bad2, hi_run2, min_gap2;
    bit seen_low2, sclk2_q, done2_q;
    int rise1, busy_cnt1, done_cnt1, sclk_hi_run1, sclk_hi_max1;
    bit sclk1_q;

    always @(negedge clk) begin
        if (sclk2 && !sclk2_q) begin
            cap2 = {cap2[14:0], mosi2};
            rise2++;
        end
        sclk2_q = sclk2;
        if (busy2) busy_cnt2++;
        if (!ss2) begin
            ss_low2++;
            if (seen_low2 && hi_run2 > 0 && hi_run2 < min_gap2) min_gap2 = hi_run2;
            seen_low2 = 1'b1;
            hi_run2 = 0;
        end else begin
            hi_run2++;
        end
        if (done2 && !busy2) done_bad2++;
        if (done2_q && busy2 && !ss2) done_bad2++;
        if (done2) begin
            if (done_cnt2 < 8) flog2[done_cnt2] = cap2;
            done_cnt2++;
        end
        done2_q = done2;

        if (sclk1 && !sclk1_q) begin
            cap1 = {cap1[14:0], mosi1};
            rise1++;
        end
        sclk1_q = sclk1;
        if (sclk1) begin
            sclk_hi_run1++;
            if (sclk_hi_run1 > sclk_hi_max1) sclk_hi_max1 = sclk_hi_run1;
        end else begin
            sclk_hi_run1 = 0;
        end
        if (busy1) busy_cnt1++;
        if (done1) done_cnt1++;
    end

    task automatic clear2();
        cap2 = '0; rise2 = 0; busy_cnt2 = 0; ss_low2 = 0; done_cnt2 = 0;
        done_bad2 = 0; hi_run2 = 0; min_gap2 = 999; seen_low2 = 1'b0;
    endtask

    task automatic clear1();
        cap1 = '0; rise1 = 0; busy_cnt1 = 0; done_cnt1 = 0;
        sclk_hi_run1 = 0; sclk_hi_max1 = 0;
    endtask

    // Waits until the chosen monitor has seen `target` done pulses, then
    // lets the DUT settle back to idle. ok=0 if the cycle budget expires.
    task automatic wait_done(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((which == 2 ? done_cnt2 : done_cnt1) >= target) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start2 = 1'b0; start1 = 1'b0; cd2 = '0; cd1 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sclk2 !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk2); end
        checks++; if (mosi2 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi2); end
        checks++; if (ss2 !== 1'b1)   begin errors++; $display("FAIL reset_ss got %b want 1", ss2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy2); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done2); end
        checks++; if ({sclk1, mosi1, ss1, busy1, done1} !== 5'b00100) begin
            errors++; $display("FAIL reset_div1 got %b want 00100", {sclk1, mosi1, ss1, busy1, done1});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        bit ok;
        clear2();
        cd2 = 14'h1234; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy2); end
        wait_done(2, 1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done want done"); end
        checks++; if (cap2 !== 16'h1234) begin errors++; $display("FAIL basic_data got %h want 1234", cap2); end
        checks++; if (rise2 != 16) begin errors++; $display("FAIL basic_rises got %0d want 16", rise2); end
        checks++; if (busy_cnt2 != 67) begin errors++; $display("FAIL basic_busy_len got %0d want 67", busy_cnt2); end
        checks++; if (ss_low2 != 66) begin errors++; $display("FAIL basic_ss_len got %0d want 66", ss_low2); end
        checks++; if (done_cnt2 != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt2); end
        checks++; if (done_bad2 != 0) begin errors++; $display("FAIL basic_done_align got %0d want 0", done_bad2); end
    endtask

    task automatic test_clk_div1();
        bit ok;
        clear1();
        cd1 = 14'h3FFF; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1, 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL div1_timeout got no done want done"); end
        checks++; if (cap1 !== 16'h3FFF) begin errors++; $display("FAIL div1_data got %h want 3fff", cap1); end
        checks++; if (cap1[15:14] !== 2'b00) begin errors++; $display("FAIL div1_top_bits got %b want 00", cap1[15:14]); end
        checks++; if (rise1 != 16) begin errors++; $display("FAIL div1_rises got %0d want 16", rise1); end
        checks++; if (sclk_hi_max1 != 1) begin errors++; $display("FAIL div1_sclk_high got %0d want 1", sclk_hi_max1); end
        checks++; if (busy_cnt1 != 34) begin errors++; $display("FAIL div1_busy_len got %0d want 34", busy_cnt1); end
    endtask

    task automatic test_ignore_start();
        bit ok;
        clear2();
        cd2 = 14'd9999; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        cd2 = 14'd0; start2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_done(2, 1, 300, ok);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout got no done want done"); end
        checks++; if (cap2 !== 16'h270F) begin errors++; $display("FAIL ignore_data got %h want 270f", cap2); end
        checks++; if (done_cnt2 != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", done_cnt2); end
        checks++; if (rise2 != 16) begin errors++; $display("FAIL ignore_rises got %0d want 16", rise2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got %b want 0", busy2); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear2();
        cd2 = 14'h0001; start2 = 1'b1;
        wait_done(2, 3, 700, ok);
        // wait_done already spent cycles; drop start right after the third done.
        start2 = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got no third done want done"); end
        checks++; if (done_cnt2 < 3) begin errors++; $display("FAIL b2b_done_count got %0d want >=3", done_cnt2); end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (flog2[f] !== 16'h0001) begin errors++; $display("FAIL b2b_frame%0d got %h want 0001", f, flog2[f]); end
        end
        checks++; if (min_gap2 < 2 || min_gap2 == 999) begin errors++; $display("FAIL b2b_ss_gap got %0d want >=2", min_gap2); end
        checks++; if (done_bad2 != 0) begin errors++; $display("FAIL b2b_done_align got %0d want 0", done_bad2); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit hit;
        clear2();
        cd2 = 14'h1234; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rise2 >= 5) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL midreset_wait got %0d rises want 5", rise2); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ss2, sclk2, mosi2, busy2} !== 4'b1000) begin
            errors++; $display("FAIL midreset_outputs got %b want 1000", {ss2, sclk2, mosi2, busy2});
        end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done_cnt2 != 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", done_cnt2); end
        clear2();
        cd2 = 14'h00AA; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_done(2, 1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout got no done want done"); end
        checks++; if (cap2 !== 16'h00AA) begin errors++; $display("FAIL midreset_data got %h want 00aa", cap2); end
        checks++; if (rise2 != 16) begin errors++; $display("FAIL midreset_rises got %0d want 16", rise2); end
    endtask

    task automatic test_data_change();
        bit ok;
        clear2();
        cd2 = 14'h2A5C; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cd2 = 14'($urandom);
            @(posedge clk); #1;
            if (done_cnt2 >= 1) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL change_timeout got no done want done"); end
        checks++; if (cap2 !== 16'h2A5C) begin errors++; $display("FAIL change_data got %h want 2a5c", cap2); end
    endtask

    initial begin
        clear2();
        clear1();
        sclk2_q = 1'b0; sclk1_q = 1'b0; done2_q = 1'b0;
        test_reset();
        test_basic_frame();
        test_clk_div1();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
